dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-ported data TCM between two requesters: port 0 is the core load/store path and port 1 is the debug/program-loader path.
- Uses round-robin arbitration with an optional lock held by port 1 for atomic multi-cycle sequences.
- Sits between the requesters and the data TCM, and owns address, write-enable, byte-enable and write-data muxing plus read-response routing.
- The TCM has one-cycle read latency, so responses return exactly one cycle after the grant.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; byte-enable width is DATA_WIDTH/8.
- ADDR_WIDTH, 32, address width in bits.
- LOCK_MAX, 16, maximum consecutive cycles port 1 may hold the lock before it is forcibly released for one arbitration.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- p0_req_i  in  1  port 0 request.
- p0_we_i  in  1  port 0 write (1) / read (0).
- p0_addr_i  in  ADDR_WIDTH  port 0 address.
- p0_be_i  in  DATA_WIDTH/8  port 0 byte enables.
- p0_wdata_i  in  DATA_WIDTH  port 0 write data.
- p0_gnt_o  out  1  port 0 grant (combinational, same cycle as request).
- p0_rvalid_o  out  1  port 0 response valid.
- p0_rdata_o  out  DATA_WIDTH  port 0 read data.
- p1_req_i, p1_we_i, p1_addr_i, p1_be_i, p1_wdata_i, p1_gnt_o, p1_rvalid_o, p1_rdata_o  same widths and meaning as port 0, for port 1.
- p1_lock_i  in  1  port 1 requests exclusive back-to-back grants.
- mem_addr_o  out  ADDR_WIDTH  TCM address.
- mem_we_o  out  1  TCM write enable.
- mem_be_o  out  DATA_WIDTH/8  TCM byte enables.
- mem_wdata_o  out  DATA_WIDTH  TCM write data.
- mem_rdata_i  in  DATA_WIDTH  TCM read data, valid one cycle after address.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - last-grant pointer = port 1, so port 0 wins the first tie.
  - FSM = ARB, lock counter = 0, p*_rvalid_o = 0, p*_rdata_o = 0.
  - Any response pending from the previous cycle is dropped.
  - While rst_n=0, both grants are forced to 0 and mem_we_o = 0.
- Grant is combinational and at most one gnt is high per cycle.
  - A granted request is issued to the TCM in the same cycle.
  - An ungranted requester must hold its req and payload stable until it is granted.
- Grant = 0 forces mem_we_o = 0 and mem_be_o = 0.
  - mem_addr_o and mem_wdata_o are don't-care when no grant; implementation drives 0.
  - Writes to the TCM happen only with gnt high.
- FSM states: ARB and LOCKED.
  - ARB: one requester present → grant it. Both present → grant the port not equal to the last-grant pointer. Pointer updates on every grant.
  - ARB → LOCKED when p1 is granted with p1_lock_i = 1.
  - LOCKED: p1 is granted whenever p1_req_i = 1; p0 is never granted. Lock counter increments each cycle spent in LOCKED.
  - LOCKED → ARB when p1_lock_i = 0, or when the counter reaches LOCK_MAX-1.
  - On forced exit, the pointer is set to p1 so p0 wins the next tie. Counter clears on exit.
  - p1_req_i = 0 while locked: stay LOCKED, issue no access, counter still increments.
- Response timing:
  - A registered tag records which port was granted and whether the access was a read.
  - Cycle N+1 after a read grant: that port's rvalid = 1 and its rdata = mem_rdata_i.
  - Writes produce rvalid = 1 in cycle N+1 with rdata = 0 (write acknowledge).
  - rvalid is a single-cycle pulse, and back-to-back grants yield back-to-back rvalid.
  - The non-target port's rdata holds its previous value.
- Simultaneous events: both requesting in every cycle → strict alternation 0,1,0,1,…
  - When p1 asserts lock in a cycle where p0 wins the tie, lock takes effect only once p1 is granted.
- Byte enables pass through unchanged; alignment and extension stay in the requester.

Test Plan:
- Reset, then p0 reads 0x10 (TCM holds 0xDEADBEEF) → p0_gnt_o = 1 in cycle 0; p0_rvalid_o = 1 with p0_rdata_o = 0xDEADBEEF in cycle 1; p1 outputs stay 0.
- Both ports request continuously for 6 cycles → grants p0,p1,p0,p1,p0,p1; each rvalid lands one cycle after its own grant.
- p1 writes 0xCAFEF00D with be = 4'b0011 to 0x20, then p0 reads 0x20 (prior contents 0x11223344) → read returns 0x1122F00D; p1_rvalid_o pulses once, the write ack.
- p1 asserts lock and request for 20 cycles with p0 requesting throughout (LOCK_MAX = 16) → p1 granted 16 consecutive cycles, then p0 granted for 1 cycle, then p1 relocks.
- Reset asserted the cycle after a p0 read grant → no p0_rvalid_o pulse; all grants and rvalids are 0 while rst_n = 0; first grant after release goes to p0 on a tie.
- p1 locked with p1_req_i = 0 and p0 requesting → no grant and mem_we_o = 0; p0 is granted the cycle after p1_lock_i deasserts.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data TCM between the core
// load/store path (port 0) and the debug/program-loader path (port 1).
// Round-robin arbitration with an optional, time-bounded lock for port 1.
// The TCM has one-cycle read latency; a registered tag routes the response.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LOCK_MAX   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // port 0: core load/store
  input  logic                    p0_req_i,
  input  logic                    p0_we_i,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic                    p0_gnt_o,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,
  // port 1: debug / program loader
  input  logic                    p1_req_i,
  input  logic                    p1_we_i,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  input  logic                    p1_lock_i,
  output logic                    p1_gnt_o,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,
  // data TCM
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  // Counter only ever needs to reach LOCK_MAX-1.
  localparam int CNT_WIDTH = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LOCK_MAX - 1);

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Arbitration state
  state_e               state_q;
  logic                 last_gnt_q;   // 1'b0 = port 0 granted last, 1'b1 = port 1
  logic [CNT_WIDTH-1:0] lock_cnt_q;
  logic [CNT_WIDTH-1:0] lock_cnt_inc_s;

  // Response tag for the access issued in the previous cycle
  logic                 tag_valid_q;
  logic                 tag_port_q;   // 1'b0 = port 0, 1'b1 = port 1
  logic                 tag_read_q;

  // Held read data for each port
  logic [DATA_WIDTH-1:0] p0_rdata_q;
  logic [DATA_WIDTH-1:0] p1_rdata_q;

  logic                  gnt0_s;
  logic                  gnt1_s;
  logic                  p0_hit_s;
  logic                  p1_hit_s;
  logic [DATA_WIDTH-1:0] resp_data_s;

  assign lock_cnt_inc_s = lock_cnt_q + CNT_WIDTH'(1);

  // Grant selection: round-robin in ARB, port 1 only in LOCKED, none in reset.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (p0_req_i && p1_req_i) begin
            if (last_gnt_q) begin
              gnt0_s = 1'b1;
            end else begin
              gnt1_s = 1'b1;
            end
          end else if (p0_req_i) begin
            gnt0_s = 1'b1;
          end else if (p1_req_i) begin
            gnt1_s = 1'b1;
          end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
          end
        end
        ST_LOCKED: begin
          gnt0_s = 1'b0;
          gnt1_s = p1_req_i;
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  assign p0_gnt_o = gnt0_s;
  assign p1_gnt_o = gnt1_s;

  // TCM request mux: everything is zeroed when nobody is granted.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (gnt0_s) begin
      mem_addr_o  = p0_addr_i;
      mem_we_o    = p0_we_i;
      mem_be_o    = p0_be_i;
      mem_wdata_o = p0_wdata_i;
    end else if (gnt1_s) begin
      mem_addr_o  = p1_addr_i;
      mem_we_o    = p1_we_i;
      mem_be_o    = p1_be_i;
      mem_wdata_o = p1_wdata_i;
    end else begin
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = {BE_WIDTH{1'b0}};
      mem_wdata_o = '0;
    end
  end

  // Arbitration FSM: ARB/LOCKED state, lock-duration counter, last-grant pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_ARB;
      lock_cnt_q <= '0;
      last_gnt_q <= 1'b1;
    end else begin
      case (state_q)
        ST_ARB: begin
          lock_cnt_q <= '0;
          if (gnt1_s && p1_lock_i) begin
            state_q <= ST_LOCKED;
          end else begin
            state_q <= ST_ARB;
          end
          if (gnt0_s) begin
            last_gnt_q <= 1'b0;
          end else if (gnt1_s) begin
            last_gnt_q <= 1'b1;
          end else begin
            last_gnt_q <= last_gnt_q;
          end
        end
        ST_LOCKED: begin
          if (!p1_lock_i) begin
            // Voluntary release
            state_q    <= ST_ARB;
            lock_cnt_q <= '0;
            last_gnt_q <= gnt1_s ? 1'b1 : last_gnt_q;
          end else if (lock_cnt_inc_s == CNT_LAST) begin
            // Forced release: port 0 is guaranteed the next tie
            state_q    <= ST_ARB;
            lock_cnt_q <= '0;
            last_gnt_q <= 1'b1;
          end else begin
            state_q    <= ST_LOCKED;
            lock_cnt_q <= lock_cnt_inc_s;
            last_gnt_q <= gnt1_s ? 1'b1 : last_gnt_q;
          end
        end
        default: begin
          state_q    <= ST_ARB;
          lock_cnt_q <= '0;
          last_gnt_q <= 1'b1;
        end
      endcase
    end
  end

  // Response routing: the tag targets one port; writes return zero data.
  assign p0_hit_s    = tag_valid_q & ~tag_port_q;
  assign p1_hit_s    = tag_valid_q &  tag_port_q;
  assign resp_data_s = tag_read_q ? mem_rdata_i : {DATA_WIDTH{1'b0}};

  assign p0_rvalid_o = rst_n & p0_hit_s;
  assign p1_rvalid_o = rst_n & p1_hit_s;
  assign p0_rdata_o  = !rst_n ? {DATA_WIDTH{1'b0}} : (p0_hit_s ? resp_data_s : p0_rdata_q);
  assign p1_rdata_o  = !rst_n ? {DATA_WIDTH{1'b0}} : (p1_hit_s ? resp_data_s : p1_rdata_q);

  // Response tag capture and per-port read-data hold registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_valid_q <= 1'b0;
      tag_port_q  <= 1'b0;
      tag_read_q  <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      tag_valid_q <= gnt0_s | gnt1_s;
      tag_port_q  <= gnt1_s;
      tag_read_q  <= gnt1_s ? ~p1_we_i : ~p0_we_i;
      p0_rdata_q  <= p0_rdata_o;
      p1_rdata_q  <= p1_rdata_o;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a table of single-cycle vectors
// plus hand-written sequences for lock expiry, idle lock and reset abort.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i, p1_lock_i;
  logic [31:0] p0_addr_i, p0_wdata_i, p1_addr_i, p1_wdata_i;
  logic [3:0]  p0_be_i, p1_be_i;
  logic        p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
  logic [31:0] p0_rdata_o, p1_rdata_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LOCK_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i), .p0_be_i(p0_be_i),
    .p0_wdata_i(p0_wdata_i), .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i), .p1_be_i(p1_be_i),
    .p1_wdata_i(p1_wdata_i), .p1_lock_i(p1_lock_i), .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o),
    .p1_rdata_o(p1_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TCM model: byte-enabled write, one-cycle registered read (old data on collision).
  logic [31:0] tb_mem [0:63];
  always @(posedge clk) begin
    if (mem_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be_o[b]) tb_mem[mem_addr_o[7:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      end
    end
    mem_rdata_i <= tb_mem[mem_addr_o[7:2]];
  end

  function automatic logic [31:0] wd(input int i);
    return 32'h5A00_0000 | 32'(i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        p0_req;
    logic        p0_we;
    logic [31:0] p0_addr;
    logic        p1_req;
    logic        p1_we;
    logic        p1_lock;
    logic [31:0] p1_addr;
    logic [3:0]  p1_be;
    logic [31:0] p1_wdata;
    logic        g0;
    logic        g1;
    logic        we;
    logic [3:0]  be;
    logic        v0;
    logic        v1;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs [15];

  task automatic drive(input logic r, input logic q0, input logic w0, input logic [31:0] a0,
                       input logic q1, input logic w1, input logic l1, input logic [31:0] a1);
    rst_n = r;
    p0_req_i = q0; p0_we_i = w0; p0_addr_i = a0;
    p1_req_i = q1; p1_we_i = w1; p1_lock_i = l1; p1_addr_i = a1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) tb_mem[i] = wd(i);
    tb_mem[4] = 32'hDEAD_BEEF;
    tb_mem[8] = 32'h1122_3344;
    p0_be_i = 4'hF; p0_wdata_i = 32'h0; p1_be_i = 4'hF; p1_wdata_i = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    //            rst   p0r   p0w   p0addr        p1r   p1w   p1l   p1addr        p1be   p1wdata         g0    g1    we    be     v0    v1    d0              d1
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h00,      1'b0, 1'b0, 1'b0, 32'h00,      4'hF,  32'h0,          1'b0, 1'b0, 1'b0, 4'h0,  1'b0, 1'b0, 32'h0,          32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h40,      1'b1, 1'b1, 1'b0, 32'h44,      4'hF,  32'h1234,       1'b0, 1'b0, 1'b0, 4'h0,  1'b0, 1'b0, 32'h0,          32'h0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h10,      1'b0, 1'b0, 1'b0, 32'h00,      4'hF,  32'h0,          1'b1, 1'b0, 1'b0, 4'hF,  1'b0, 1'b0, 32'h0,          32'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h00,      1'b0, 1'b0, 1'b0, 32'h00,      4'hF,  32'h0,          1'b0, 1'b0, 1'b0, 4'h0,  1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h00,      1'b1, 1'b0, 1'b0, 32'h08,      4'hF,  32'h0,          1'b0, 1'b1, 1'b0, 4'hF,  1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h04,      1'b1, 1'b0, 1'b0, 32'h0C,      4'hF,  32'h0,          1'b1, 1'b0, 1'b0, 4'hF,  1'b0, 1'b1, 32'hDEAD_BEEF, wd(2)};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h14,      1'b1, 1'b0, 1'b0, 32'h0C,      4'hF,  32'h0,          1'b0, 1'b1, 1'b0, 4'hF,  1'b1, 1'b0, wd(1),          wd(2)};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h14,      1'b1, 1'b0, 1'b0, 32'h18,      4'hF,  32'h0,          1'b1, 1'b0, 1'b0, 4'hF,  1'b0, 1'b1, wd(1),          wd(3)};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h1C,      1'b1, 1'b0, 1'b0, 32'h18,      4'hF,  32'h0,          1'b0, 1'b1, 1'b0, 4'hF,  1'b1, 1'b0, wd(5),          wd(3)};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h1C,      1'b1, 1'b0, 1'b0, 32'h24,      4'hF,  32'h0,          1'b1, 1'b0, 1'b0, 4'hF,  1'b0, 1'b1, wd(5),          wd(6)};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h00,      1'b1, 1'b0, 1'b0, 32'h24,      4'hF,  32'h0,          1'b0, 1'b1, 1'b0, 4'hF,  1'b1, 1'b0, wd(7),          wd(6)};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h00,      1'b0, 1'b0, 1'b0, 32'h00,      4'hF,  32'h0,          1'b0, 1'b0, 1'b0, 4'h0,  1'b0, 1'b1, wd(7),          wd(9)};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h00,      1'b1, 1'b1, 1'b0, 32'h20,      4'h3,  32'hCAFE_F00D,  1'b0, 1'b1, 1'b1, 4'h3,  1'b0, 1'b0, wd(7),          wd(9)};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h20,      1'b0, 1'b0, 1'b0, 32'h00,      4'hF,  32'h0,          1'b1, 1'b0, 1'b0, 4'hF,  1'b0, 1'b1, wd(7),          32'h0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h00,      1'b0, 1'b0, 1'b0, 32'h00,      4'hF,  32'h0,          1'b0, 1'b0, 1'b0, 4'h0,  1'b1, 1'b0, 32'h1122_F00D, 32'h0};

    next_cycle();

    // Table-driven vectors
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst_n, vecs[i].p0_req, vecs[i].p0_we, vecs[i].p0_addr,
            vecs[i].p1_req, vecs[i].p1_we, vecs[i].p1_lock, vecs[i].p1_addr);
      p1_be_i = vecs[i].p1_be;
      p1_wdata_i = vecs[i].p1_wdata;
      @(negedge clk);
      chk($sformatf("v%0d gnt0", i), {31'b0, p0_gnt_o}, {31'b0, vecs[i].g0});
      chk($sformatf("v%0d gnt1", i), {31'b0, p1_gnt_o}, {31'b0, vecs[i].g1});
      chk($sformatf("v%0d mem_we", i), {31'b0, mem_we_o}, {31'b0, vecs[i].we});
      chk($sformatf("v%0d mem_be", i), {28'b0, mem_be_o}, {28'b0, vecs[i].be});
      chk($sformatf("v%0d rvalid0", i), {31'b0, p0_rvalid_o}, {31'b0, vecs[i].v0});
      chk($sformatf("v%0d rvalid1", i), {31'b0, p1_rvalid_o}, {31'b0, vecs[i].v1});
      chk($sformatf("v%0d rdata0", i), p0_rdata_o, vecs[i].d0);
      chk($sformatf("v%0d rdata1", i), p1_rdata_o, vecs[i].d1);
      next_cycle();
    end
    p1_be_i = 4'hF;
    p1_wdata_i = 32'h0;

    // Lock expiry: p1 holds lock for 20 cycles while p0 requests throughout
    drive(1'b1, 1'b1, 1'b0, 32'h04, 1'b1, 1'b0, 1'b1, 32'h08);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("lock%0d gnt0", i), {31'b0, p0_gnt_o}, {31'b0, (i == 16)});
      chk($sformatf("lock%0d gnt1", i), {31'b0, p1_gnt_o}, {31'b0, (i != 16)});
      if (i == 17) begin
        chk("lock p0 rvalid", {31'b0, p0_rvalid_o}, 32'd1);
        chk("lock p0 rdata", p0_rdata_o, wd(1));
      end
      next_cycle();
    end

    // Idle lock: p1 locked without request, p0 writing
    p0_wdata_i = 32'h0BAD_CAFE;
    drive(1'b1, 1'b1, 1'b1, 32'h28, 1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d gnt0", i), {31'b0, p0_gnt_o}, 32'd0);
      chk($sformatf("idle%0d gnt1", i), {31'b0, p1_gnt_o}, 32'd0);
      chk($sformatf("idle%0d mem_we", i), {31'b0, mem_we_o}, 32'd0);
      next_cycle();
    end
    p1_lock_i = 1'b0;
    @(negedge clk);
    chk("unlock cycle gnt0", {31'b0, p0_gnt_o}, 32'd0);
    chk("unlock cycle mem_we", {31'b0, mem_we_o}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("after unlock gnt0", {31'b0, p0_gnt_o}, 32'd1);
    chk("after unlock mem_we", {31'b0, mem_we_o}, 32'd1);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("write ack rvalid0", {31'b0, p0_rvalid_o}, 32'd1);
    chk("write ack rdata0", p0_rdata_o, 32'h0);
    chk("tcm word 0x28", tb_mem[10], 32'h0BAD_CAFE);
    next_cycle();

    // Reset aborts a pending read response
    drive(1'b1, 1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("pre-reset gnt0", {31'b0, p0_gnt_o}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 1'b0, 1'b0, 32'h08);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("rst%0d rvalid0", i), {31'b0, p0_rvalid_o}, 32'd0);
      chk($sformatf("rst%0d rvalid1", i), {31'b0, p1_rvalid_o}, 32'd0);
      chk($sformatf("rst%0d gnt0", i), {31'b0, p0_gnt_o}, 32'd0);
      chk($sformatf("rst%0d gnt1", i), {31'b0, p1_gnt_o}, 32'd0);
      if (i == 1) begin
        chk("rst rdata0", p0_rdata_o, 32'h0);
        chk("rst rdata1", p1_rdata_o, 32'h0);
      end
      next_cycle();
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset tie gnt0", {31'b0, p0_gnt_o}, 32'd1);
    chk("post-reset tie gnt1", {31'b0, p1_gnt_o}, 32'd0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h08);
    @(negedge clk);
    chk("post-reset rvalid0", {31'b0, p0_rvalid_o}, 32'd1);
    chk("post-reset rdata0", p0_rdata_o, 32'hDEAD_BEEF);
    chk("post-reset rvalid1", {31'b0, p1_rvalid_o}, 32'd0);
    chk("post-reset gnt1", {31'b0, p1_gnt_o}, 32'd1);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
